// File: rtl/time_setter_pkg.sv
// Shared definitions for the time-setting front end: mode encoding and field limits.
package time_setter_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } mode_t;

  localparam logic [4:0] HOURS_MAX   = 5'd23;
  localparam logic [5:0] MINUTES_MAX = 6'd59;

endpackage

// File: rtl/time_setter_btn_debounce.sv
// Button front end: 2-flop synchronizer, counting debouncer and rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          armed;
  logic [CW-1:0] cnt;

  // Synchronizer chain; resets to "pressed" so a button held through reset is never seen as a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a level change after DEBOUNCE_CYCLES differing samples; pulse only once a release has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      press <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      press <= 1'b0;
      if (!sync2) armed <= 1'b1;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          press <= sync2 & armed;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/time_setter.sv
// Time-setting controller: mode FSM, shadow hours/minutes, auto-repeat, idle timeout and blink.
module time_setter
  import time_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10,
  parameter int BLINK_HALF      = 25,
  parameter int TIMEOUT         = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic [4:0] set_hours,
  output logic [5:0] set_minutes,
  output logic       load,
  output logic       hold,
  output logic [1:0] mode,
  output logic       blink
);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  mode_t         state, state_n;
  logic          mode_ev, inc_ev, inc_level, mode_level;
  logic [4:0]    hours_n;
  logic [5:0]    mins_n;
  logic          load_n, hold_n, blink_n, ract, ract_n, bump;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [BW-1:0] bcnt, bcnt_n;

  function automatic logic [4:0] next_hour(input logic [4:0] h);
    return (h >= HOURS_MAX) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] next_minute(input logic [5:0] m);
    return (m >= MINUTES_MAX) ? 6'd0 : m + 6'd1;
  endfunction

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst(rst), .raw(btn_mode), .level(mode_level), .press(mode_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst(rst), .raw(btn_inc), .level(inc_level), .press(inc_ev)
  );

  assign mode = state;

  // Mode state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  // Next-state and next-value logic; mode press beats inc, events beat timeout.
  always_comb begin
    state_n = state;
    hours_n = set_hours;
    mins_n  = set_minutes;
    load_n  = 1'b0;
    hold_n  = hold;
    blink_n = blink;
    bcnt_n  = bcnt;
    rcnt_n  = rcnt;
    ract_n  = ract;
    icnt_n  = icnt;
    bump    = 1'b0;
    case (state)
      RUN: begin
        hold_n  = 1'b0;
        blink_n = 1'b0;
        bcnt_n  = '0;
        rcnt_n  = '0;
        ract_n  = 1'b0;
        icnt_n  = '0;
        if (mode_ev) begin
          state_n = SET_H;
          hours_n = cur_hours;
          mins_n  = cur_minutes;
          hold_n  = 1'b1;
          blink_n = 1'b1;
        end
      end
      SET_H, SET_M: begin
        if (mode_ev) begin
          rcnt_n  = '0;
          ract_n  = 1'b0;
          icnt_n  = '0;
          bcnt_n  = '0;
          if (state == SET_H) begin
            state_n = SET_M;
            blink_n = 1'b1;
          end else begin
            state_n = RUN;
            load_n  = 1'b1;
            hold_n  = 1'b0;
            blink_n = 1'b0;
          end
        end else begin
          if (inc_ev) begin
            bump   = 1'b1;
            ract_n = 1'b1;
            rcnt_n = '0;
          end else if (ract && inc_level) begin
            if (rcnt == RW'(REPEAT_DELAY - 1)) begin
              bump   = 1'b1;
              rcnt_n = RW'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
              rcnt_n = rcnt + 1'b1;
            end
          end else begin
            ract_n = 1'b0;
            rcnt_n = '0;
          end
          if (bump) begin
            if (state == SET_H) hours_n = next_hour(set_hours);
            else                mins_n  = next_minute(set_minutes);
            icnt_n  = '0;
            blink_n = 1'b1;
            bcnt_n  = '0;
          end else if (icnt == IW'(TIMEOUT - 1)) begin
            state_n = RUN;
            hold_n  = 1'b0;
            blink_n = 1'b0;
            bcnt_n  = '0;
            ract_n  = 1'b0;
            rcnt_n  = '0;
            icnt_n  = '0;
          end else begin
            icnt_n = icnt + 1'b1;
            if (bcnt == BW'(BLINK_HALF - 1)) begin
              blink_n = ~blink;
              bcnt_n  = '0;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = RUN;
        hold_n  = 1'b0;
        blink_n = 1'b0;
      end
    endcase
  end

  // Registered outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_hours   <= '0;
      set_minutes <= '0;
      load        <= 1'b0;
      hold        <= 1'b0;
      blink       <= 1'b0;
      bcnt        <= '0;
      rcnt        <= '0;
      ract        <= 1'b0;
      icnt        <= '0;
    end else begin
      set_hours   <= hours_n;
      set_minutes <= mins_n;
      load        <= load_n;
      hold        <= hold_n;
      blink       <= blink_n;
      bcnt        <= bcnt_n;
      rcnt        <= rcnt_n;
      ract        <= ract_n;
      icnt        <= icnt_n;
    end
  end

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter: table of edit sessions plus hand sequences for timing corners.
module tb_time_setter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       load, hold, blink;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_fail = 0;
  int load_cnt = 0;
  int load_h = 0;
  int load_m = 0;

  time_setter #(
    .DEBOUNCE_CYCLES(3), .REPEAT_DELAY(50), .REPEAT_RATE(10),
    .BLINK_HALF(25), .TIMEOUT(3000)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .set_hours(set_hours), .set_minutes(set_minutes),
    .load(load), .hold(hold), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  // Record every load pulse and the value presented with it.
  always @(negedge clk) begin
    if (load) begin
      load_cnt <= load_cnt + 1;
      load_h   <= int'(set_hours);
      load_m   <= int'(set_minutes);
    end
  end

  typedef struct {
    int ch; int cm; int nh; int nm; int eh; int em;
  } session_t;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press of 6 cycles; the event is visible on return from the first step.
  task automatic tap_mode();
    btn_mode = 1'b1; step(6); btn_mode = 1'b0; step(8);
  endtask

  task automatic tap_inc();
    btn_inc = 1'b1; step(6); btn_inc = 1'b0; step(8);
  endtask

  task automatic enter(input int h, input int m);
    cur_hours = 5'(h); cur_minutes = 6'(m);
    tap_mode();
  endtask

  session_t tbl[5];
  int lc;

  initial begin
    tbl[0] = '{13, 45, 0, 0, 13, 45};
    tbl[1] = '{23, 59, 1, 1,  0,  0};
    tbl[2] = '{ 5, 10, 3, 2,  8, 12};
    tbl[3] = '{22, 58, 2, 2,  0,  0};
    tbl[4] = '{ 0,  0, 1, 0,  1,  0};

    // Reset values.
    #1;
    check("rst_mode", int'(mode), 0);
    check("rst_hold", int'(hold), 0);
    check("rst_blink", int'(blink), 0);
    check("rst_set", int'({set_hours, set_minutes}), 0);
    step(3);
    rst = 1'b0;
    step(5);

    // Press latency: effect on the 6th rising edge after the raw edge.
    cur_hours = 5'd13; cur_minutes = 6'd45;
    btn_mode = 1'b1;
    step(5);
    check("lat_before", int'(mode), 0);
    step(1);
    check("lat_mode", int'(mode), 1);
    check("lat_hold", int'(hold), 1);
    check("lat_blink", int'(blink), 1);
    check("lat_set_h", int'(set_hours), 13);
    check("lat_set_m", int'(set_minutes), 45);
    btn_mode = 1'b0; step(8);
    tap_mode(); tap_mode();
    check("lat_exit", int'(mode), 0);
    check("lat_loads", load_cnt, 1);

    // Table of full edit sessions.
    for (int i = 0; i < 5; i++) begin
      lc = load_cnt;
      enter(tbl[i].ch, tbl[i].cm);
      check("tb_mode_h", int'(mode), 1);
      check("tb_cap_h", int'(set_hours), tbl[i].ch);
      check("tb_cap_m", int'(set_minutes), tbl[i].cm);
      for (int k = 0; k < tbl[i].nh; k++) tap_inc();
      check("tb_hours", int'(set_hours), tbl[i].eh);
      tap_mode();
      check("tb_mode_m", int'(mode), 2);
      for (int k = 0; k < tbl[i].nm; k++) tap_inc();
      check("tb_minutes", int'(set_minutes), tbl[i].em);
      tap_mode();
      check("tb_mode_run", int'(mode), 0);
      check("tb_hold", int'(hold), 0);
      check("tb_blink", int'(blink), 0);
      check("tb_one_load", load_cnt - lc, 1);
      check("tb_load_val", load_h * 100 + load_m, tbl[i].eh * 100 + tbl[i].em);
    end

    // Auto-repeat: event at 0, repeats at 50,60,...,100.
    enter(0, 0); tap_mode();
    btn_inc = 1'b1;
    step(6);
    check("rep_first", int'(set_minutes), 1);
    step(49);
    check("rep_pre50", int'(set_minutes), 1);
    step(1);
    check("rep_at50", int'(set_minutes), 2);
    step(53);
    btn_inc = 1'b0;
    step(20);
    check("rep_total", int'(set_minutes), 7);
    tap_mode();

    // Glitch and simultaneous press.
    enter(7, 20);
    btn_inc = 1'b1; step(2); btn_inc = 1'b0; step(10);
    check("glitch_h", int'(set_hours), 7);
    btn_inc = 1'b1; btn_mode = 1'b1;
    step(6);
    check("both_mode", int'(mode), 2);
    check("both_h", int'(set_hours), 7);
    check("both_m", int'(set_minutes), 20);
    btn_inc = 1'b0; btn_mode = 1'b0; step(8);
    tap_mode();

    // Inc held across a mode change produces no repeats.
    enter(3, 30);
    btn_inc = 1'b1; step(10);
    btn_mode = 1'b1; step(6);
    check("cross_mode", int'(mode), 2);
    btn_mode = 1'b0; step(70);
    btn_inc = 1'b0; step(10);
    check("cross_h", int'(set_hours), 4);
    check("cross_m", int'(set_minutes), 30);
    tap_mode();

    // Blink period and idle timeout.
    lc = load_cnt;
    cur_hours = 5'd9; cur_minutes = 6'd9;
    btn_mode = 1'b1; step(6); btn_mode = 1'b0;
    check("to_enter", int'(mode), 1);
    step(24);
    check("blink_hi", int'(blink), 1);
    step(1);
    check("blink_lo", int'(blink), 0);
    step(2974);
    check("to_before", int'(mode), 1);
    step(1);
    check("to_mode", int'(mode), 0);
    check("to_hold", int'(hold), 0);
    check("to_noload", load_cnt - lc, 0);

    // Reset in the middle of SET_M.
    lc = load_cnt;
    enter(11, 11); tap_mode(); tap_inc();
    rst = 1'b1; #1;
    check("mr_mode", int'(mode), 0);
    check("mr_hold", int'(hold), 0);
    check("mr_blink", int'(blink), 0);
    check("mr_set", int'({set_hours, set_minutes}), 0);
    step(3); rst = 1'b0; step(10);
    check("mr_noload", load_cnt - lc, 0);

    // Button held through reset release gives no event until re-pressed.
    btn_mode = 1'b1; step(2);
    rst = 1'b1; step(3); rst = 1'b0;
    step(20);
    check("held_rst", int'(mode), 0);
    btn_mode = 1'b0; step(10);
    tap_mode();
    check("held_repress", int'(mode), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
